// File: rtl/block_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : block_instr_fetch
// Purpose  : Per-sample instruction sequencer for one DSP block. On each
//            accepted sample tick it walks instruction memory from address 0
//            to len-1 and presents one word per cycle to the decoder. A
//            2-entry buffer (output register + skid) absorbs the 1-cycle RAM
//            read latency so downstream stalls never lose or repeat a word.
// Ports    : clk, reset          clock, asynchronous active-high reset
//            sample_tick         one-cycle pulse, starts a program run
//            prog_len            program length, sampled on accepted tick
//            mem_addr/mem_rd_en  instruction RAM read request
//            mem_rdata           RAM data, valid the cycle after mem_rd_en
//            instr/instr_pc      word and its address to the decoder
//            instr_valid, stall  presentation handshake
//            busy, done          run in progress / one-cycle completion pulse
//            overrun             sticky: tick seen while busy
//            clear_overrun       clears overrun (a same-cycle set wins)
// Revision : 1.0  initial release
// ============================================================================
module block_instr_fetch #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_tick,
  input  logic [ADDR_WIDTH:0]    prog_len,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_rd_en,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   instr_valid,
  input  logic                   stall,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  input  logic                   clear_overrun
);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_run  = 1'b1;

  localparam logic [ADDR_WIDTH:0] c_max_len = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] c_one     = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] c_zero    = '0;

  logic [0:0]             r_state;
  logic [ADDR_WIDTH:0]    r_len;
  logic [ADDR_WIDTH:0]    r_issue_ptr;
  logic [ADDR_WIDTH:0]    r_xfer_cnt;
  logic                   r_inflight;
  logic [ADDR_WIDTH-1:0]  r_inflight_pc;
  logic                   r_out_valid;
  logic [INSTR_WIDTH-1:0] r_out_data;
  logic [ADDR_WIDTH-1:0]  r_out_pc;
  logic                   r_skid_valid;
  logic [INSTR_WIDTH-1:0] r_skid_data;
  logic [ADDR_WIDTH-1:0]  r_skid_pc;
  logic                   r_done;
  logic                   r_overrun;

  logic                   w_xfer;
  logic [1:0]             w_pending;
  logic                   w_room;
  logic                   w_issue;
  logic                   w_last;
  logic [ADDR_WIDTH:0]    w_len_in;

  logic                   w_out_valid_n;
  logic [INSTR_WIDTH-1:0] w_out_data_n;
  logic [ADDR_WIDTH-1:0]  w_out_pc_n;
  logic                   w_skid_valid_n;
  logic [INSTR_WIDTH-1:0] w_skid_data_n;
  logic [ADDR_WIDTH-1:0]  w_skid_pc_n;

  // The head of the queue is the output register when it is full; otherwise
  // the word returning from RAM is presented straight through, which is what
  // gives pc 0 two cycles after the tick and one word per cycle thereafter.
  assign instr_valid = r_out_valid | r_inflight;
  assign instr       = r_out_valid ? r_out_data :
                       (r_inflight ? mem_rdata : '0);
  assign instr_pc    = r_out_valid ? r_out_pc :
                       (r_inflight ? r_inflight_pc : '0);

  assign w_xfer    = instr_valid & ~stall;
  // Words buffered plus the one in flight; never exceeds 2 by construction.
  assign w_pending = {1'b0, r_out_valid} + {1'b0, r_skid_valid} + {1'b0, r_inflight};
  assign w_room    = w_pending < (2'd2 + {1'b0, w_xfer});
  assign w_issue   = (r_state == c_st_run) && (r_issue_ptr < r_len) && w_room;
  assign w_last    = w_xfer && ((r_xfer_cnt + c_one) == r_len);
  assign w_len_in  = (prog_len > c_max_len) ? c_max_len : prog_len;

  assign mem_addr  = r_issue_ptr[ADDR_WIDTH-1:0];
  assign mem_rd_en = w_issue;
  assign busy      = (r_state == c_st_run);
  assign done      = r_done;
  assign overrun   = r_overrun;

  // FIFO update: pop the head on a transfer, then compact what remains
  // (output register, skid, returning word) into the two storage slots.
  always_comb begin
    w_out_valid_n  = r_out_valid;
    w_out_data_n   = r_out_data;
    w_out_pc_n     = r_out_pc;
    w_skid_valid_n = r_skid_valid;
    w_skid_data_n  = r_skid_data;
    w_skid_pc_n    = r_skid_pc;
    if (r_out_valid) begin
      if (w_xfer) begin
        if (r_skid_valid) begin
          w_out_data_n   = r_skid_data;
          w_out_pc_n     = r_skid_pc;
          w_skid_valid_n = r_inflight;
          w_skid_data_n  = mem_rdata;
          w_skid_pc_n    = r_inflight_pc;
        end else if (r_inflight) begin
          w_out_data_n   = mem_rdata;
          w_out_pc_n     = r_inflight_pc;
        end else begin
          w_out_valid_n  = 1'b0;
        end
      end else if (r_inflight) begin
        w_skid_valid_n = 1'b1;
        w_skid_data_n  = mem_rdata;
        w_skid_pc_n    = r_inflight_pc;
      end
    end else if (r_inflight && !w_xfer) begin
      // Bypassed word was stalled: park it so it stays stable.
      w_out_valid_n = 1'b1;
      w_out_data_n  = mem_rdata;
      w_out_pc_n    = r_inflight_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_pc     <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_pc    <= '0;
    end else begin
      r_out_valid  <= w_out_valid_n;
      r_out_data   <= w_out_data_n;
      r_out_pc     <= w_out_pc_n;
      r_skid_valid <= w_skid_valid_n;
      r_skid_data  <= w_skid_data_n;
      r_skid_pc    <= w_skid_pc_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= c_st_idle;
      r_len         <= c_zero;
      r_issue_ptr   <= c_zero;
      r_xfer_cnt    <= c_zero;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_done        <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= mem_addr;
        r_issue_ptr   <= r_issue_ptr + c_one;
      end
      if (w_xfer) begin
        r_xfer_cnt <= r_xfer_cnt + c_one;
      end
      case (r_state)
        c_st_idle: begin
          if (sample_tick) begin
            r_len       <= w_len_in;
            r_issue_ptr <= c_zero;
            r_xfer_cnt  <= c_zero;
            if (w_len_in == c_zero) begin
              r_done <= 1'b1;
            end else begin
              r_state <= c_st_run;
            end
          end
        end
        default: begin
          if (w_last) begin
            r_state <= c_st_idle;
            r_done  <= 1'b1;
          end
        end
      endcase
      if (sample_tick && (r_state == c_st_run)) begin
        r_overrun <= 1'b1;
      end else if (clear_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_block_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_instr_fetch
// Purpose  : Self-checking bench for block_instr_fetch. A per-cycle vector
//            table covers basic, stalled, edge-length, overrun and
//            back-to-back runs; hand-written sequences cover reset mid-run,
//            long runs under random stall and length clamping.
// Revision : 1.0  initial release
// ============================================================================
module tb_block_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic [8:0]  prog_len;
  logic [7:0]  mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        stall;
  logic        busy;
  logic        done;
  logic        overrun;
  logic        clear_overrun;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [256];

  always #5 clk = ~clk;

  // Synchronous instruction RAM, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  block_instr_fetch #(.INSTR_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .prog_len(prog_len),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .stall(stall), .busy(busy), .done(done), .overrun(overrun),
    .clear_overrun(clear_overrun)
  );

  typedef struct {
    logic       tick;
    logic [8:0] len;
    logic       stl;
    logic       clr;
    logic       busy;
    logic       rd;
    logic [7:0] addr;
    logic       valid;
    logic [7:0] pc;
    logic       done;
    logic       ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic t, input logic [8:0] l, input logic s, input logic c,
                   input logic b, input logic r, input logic [7:0] a,
                   input logic vv, input logic [7:0] p, input logic d, input logic o);
    vec_t x;
    x.tick = t; x.len = l; x.stl = s; x.clr = c; x.busy = b; x.rd = r;
    x.addr = a; x.valid = vv; x.pc = p; x.done = d; x.ovr = o;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic idle_inputs();
    sample_tick = 1'b0; prog_len = '0; stall = 1'b0; clear_overrun = 1'b0;
  endtask

  // Starts a run and streams it to completion under optional random stall,
  // checking order, buffer occupancy and the done pulse.
  task automatic run_stream(input string name, input logic [8:0] len_in,
                            input int exp_count, input bit rnd_stall);
    int issued = 0;
    int xfers = 0;
    int dones = 0;
    int max_pend = 0;
    int cyc = 0;
    bit order_ok = 1'b1;
    bit addr_ok = 1'b1;
    bit finished = 1'b0;
    logic [7:0] exp_pc = 8'd0;
    @(negedge clk);
    idle_inputs();
    sample_tick = 1'b1; prog_len = len_in;
    @(negedge clk);
    sample_tick = 1'b0; prog_len = 9'd3;
    while (!finished && cyc < 4000) begin
      stall = rnd_stall ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (issued - xfers > max_pend) max_pend = issued - xfers;
      if (mem_rd_en) begin
        if (mem_addr != 8'(issued)) addr_ok = 1'b0;
        issued++;
      end
      if (instr_valid && !stall) begin
        if (instr_pc != exp_pc || instr != 32'h100 + {24'd0, exp_pc}) begin
          if (order_ok)
            $display("FAIL %s order: got pc %0d instr %h, need pc %0d instr %h",
                     name, instr_pc, instr, exp_pc, 32'h100 + {24'd0, exp_pc});
          order_ok = 1'b0;
        end
        exp_pc++;
        xfers++;
      end
      if (done) begin
        dones++;
        finished = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    stall = 1'b0;
    chk({name, " finish"}, finished, $sformatf("no done within %0d cycles", cyc));
    for (int i = 0; i < 4; i++) begin
      #1;
      if (done) dones++;
      if (instr_valid || mem_rd_en) order_ok = 1'b0;
      @(negedge clk);
    end
    chk({name, " order"}, order_ok, "transfer sequence or post-run idle wrong");
    chk({name, " addr"}, addr_ok, "read addresses not sequential from 0");
    chk({name, " count"}, xfers == exp_count, $sformatf("got %0d transfers, need %0d", xfers, exp_count));
    chk({name, " occupancy"}, max_pend <= 2, $sformatf("got %0d pending, need <= 2", max_pend));
    chk({name, " done"}, dones == 1, $sformatf("got %0d done pulses, need 1", dones));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h100 + i;
    mem_rdata = '0;
    idle_inputs();
    reset = 1'b1;

    // ---- basic run, len 4
    v(1,4,0,0, 0,0,0,0,0,0,0); v(0,0,0,0, 1,1,0,0,0,0,0); v(0,0,0,0, 1,1,1,1,0,0,0);
    v(0,0,0,0, 1,1,2,1,1,0,0); v(0,0,0,0, 1,1,3,1,2,0,0); v(0,0,0,0, 1,0,0,1,3,0,0);
    v(0,0,0,0, 0,0,0,0,0,1,0); v(0,0,0,0, 0,0,0,0,0,0,0);
    // ---- len 6, pc 2 stalled for 3 cycles
    v(1,6,0,0, 0,0,0,0,0,0,0); v(0,0,0,0, 1,1,0,0,0,0,0); v(0,0,0,0, 1,1,1,1,0,0,0);
    v(0,0,0,0, 1,1,2,1,1,0,0); v(0,0,1,0, 1,1,3,1,2,0,0); v(0,0,1,0, 1,0,0,1,2,0,0);
    v(0,0,1,0, 1,0,0,1,2,0,0); v(0,0,0,0, 1,1,4,1,2,0,0); v(0,0,0,0, 1,1,5,1,3,0,0);
    v(0,0,0,0, 1,0,0,1,4,0,0); v(0,0,0,0, 1,0,0,1,5,0,0); v(0,0,0,0, 0,0,0,0,0,1,0);
    v(0,0,0,0, 0,0,0,0,0,0,0);
    // ---- len 0, then len 1
    v(1,0,0,0, 0,0,0,0,0,0,0); v(0,0,0,0, 0,0,0,0,0,1,0); v(0,0,0,0, 0,0,0,0,0,0,0);
    v(1,1,0,0, 0,0,0,0,0,0,0); v(0,0,0,0, 1,1,0,0,0,0,0); v(0,0,0,0, 1,0,0,1,0,0,0);
    v(0,0,0,0, 0,0,0,0,0,1,0); v(0,0,0,0, 0,0,0,0,0,0,0);
    // ---- overrun: busy ticks (incl. final-transfer cycle), clear, set-wins
    v(1,3,0,0, 0,0,0,0,0,0,0); v(0,0,0,0, 1,1,0,0,0,0,0); v(1,5,0,0, 1,1,1,1,0,0,0);
    v(0,0,0,0, 1,1,2,1,1,0,1); v(1,2,0,0, 1,0,0,1,2,0,1); v(0,0,0,1, 0,0,0,0,0,1,1);
    v(0,0,0,0, 0,0,0,0,0,0,0); v(1,2,0,0, 0,0,0,0,0,0,0); v(0,0,0,0, 1,1,0,0,0,0,0);
    v(1,7,0,1, 1,1,1,1,0,0,0); v(0,0,0,0, 1,0,0,1,1,0,1); v(0,0,0,0, 0,0,0,0,0,1,1);
    v(0,0,0,1, 0,0,0,0,0,0,1); v(0,0,0,0, 0,0,0,0,0,0,0);
    // ---- tick in the done cycle starts a new run
    v(1,2,0,0, 0,0,0,0,0,0,0); v(0,0,0,0, 1,1,0,0,0,0,0); v(0,0,0,0, 1,1,1,1,0,0,0);
    v(0,0,0,0, 1,0,0,1,1,0,0); v(1,1,0,0, 0,0,0,0,0,1,0); v(0,0,0,0, 1,1,0,0,0,0,0);
    v(0,0,0,0, 1,0,0,1,0,0,0); v(0,0,0,0, 0,0,0,0,0,1,0); v(0,0,0,0, 0,0,0,0,0,0,0);

    // ---- reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", {busy, mem_rd_en, mem_addr, instr_valid, instr, instr_pc, done, overrun} == '0,
        $sformatf("got busy=%b rd=%b addr=%0d valid=%b instr=%h pc=%0d done=%b ovr=%b, need all 0",
                  busy, mem_rd_en, mem_addr, instr_valid, instr, instr_pc, done, overrun));
    @(negedge clk);
    reset = 1'b0;

    // ---- vector table
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t e;
      bit ok;
      e = vecs[i];
      @(negedge clk);
      sample_tick = e.tick; prog_len = e.len; stall = e.stl; clear_overrun = e.clr;
      #1;
      ok = (busy == e.busy) && (mem_rd_en == e.rd) && (!e.rd || mem_addr == e.addr) &&
           (instr_valid == e.valid) &&
           (!e.valid || (instr_pc == e.pc && instr == 32'h100 + {24'd0, e.pc})) &&
           (done == e.done) && (overrun == e.ovr);
      chk($sformatf("vec[%0d]", i), ok,
          $sformatf("got busy=%b rd=%b addr=%0d valid=%b pc=%0d instr=%h done=%b ovr=%b; need busy=%b rd=%b addr=%0d valid=%b pc=%0d instr=%h done=%b ovr=%b",
                    busy, mem_rd_en, mem_addr, instr_valid, instr_pc, instr, done, overrun,
                    e.busy, e.rd, e.addr, e.valid, e.pc, 32'h100 + {24'd0, e.pc}, e.done, e.ovr));
    end

    // ---- asynchronous reset mid-run with a read in flight
    @(negedge clk);
    idle_inputs();
    sample_tick = 1'b1; prog_len = 9'd4;
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    #1;
    chk("pre_reset", mem_rd_en && instr_valid && overrun,
        $sformatf("got rd=%b valid=%b ovr=%b, need 1 1 1", mem_rd_en, instr_valid, overrun));
    #1 reset = 1'b1;
    #1;
    chk("async_reset", {busy, mem_rd_en, mem_addr, instr_valid, instr, instr_pc, done, overrun} == '0,
        $sformatf("got busy=%b rd=%b addr=%0d valid=%b instr=%h pc=%0d done=%b ovr=%b, need all 0",
                  busy, mem_rd_en, mem_addr, instr_valid, instr, instr_pc, done, overrun));
    repeat (2) @(negedge clk);
    #1;
    chk("reset_hold", !instr_valid && !done,
        $sformatf("got valid=%b done=%b during reset, need 0 0", instr_valid, done));
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post_reset_idle", !instr_valid && !done && !busy,
        $sformatf("got valid=%b done=%b busy=%b, need 0 0 0", instr_valid, done, busy));
    run_stream("after_reset", 9'd4, 4, 1'b0);

    // ---- long runs: random stall, then clamped length
    run_stream("rand256", 9'd256, 256, 1'b1);
    run_stream("clamp", 9'h1FF, 256, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
